counter_arbiter: RTL

- Shares one BW-bit cycle counter between NREQ requesters.
- Each requester asks for a timed interval of len cycles. The arbiter grants one requester at a time, runs the counter for the requested length, then pulses that requester's done.
- Sits between client blocks needing delays/timeouts and a single counter datapath, so each client does not need its own counter.

---
 rtl/counter_arbiter_pkg.sv | 14 +
 rtl/arb_count_core.sv | 36 +++
 rtl/counter_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/counter_arbiter_pkg.sv
// Shared definitions for the counter arbiter: FSM state encoding and default sizes.
package counter_arbiter_pkg;

  localparam int BW_DEFAULT   = 4;
  localparam int NREQ_DEFAULT = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/arb_count_core.sv
// BW-bit up-counter with async reset and synchronous clear (clear beats enable).
module arb_count_core
  import counter_arbiter_pkg::*;
#(
  parameter int BW = BW_DEFAULT
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [BW-1:0] count_o
);

  logic [BW-1:0] count_q;
  logic [BW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/counter_arbiter.sv
// Arbitrates NREQ requesters onto one shared interval counter (arb_count_core).
// Define COUNTER_ARBITER_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module counter_arbiter
  import counter_arbiter_pkg::*;
#(
  parameter int BW   = BW_DEFAULT,
  parameter int NREQ = NREQ_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [NREQ-1:0]  req_i,
  input  logic [NREQ*BW-1:0] len_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic [NREQ-1:0]  done_o,
  output logic             busy_o,
  output logic [BW-1:0]    count_o
);

  localparam int IDW = $clog2(NREQ);

  state_e          state_q;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] done_q;
  logic            busy_q;
  logic [IDW-1:0]  w_q;
  logic [BW-1:0]   len_q;

  logic [IDW-1:0]  pick;
  logic            pick_vld;
  logic [BW-1:0]   len_sel;
  logic            req_w;
  logic            abort;
  logic            cnt_clr;
  logic            cnt_en;
  logic [BW-1:0]   count;

`ifdef COUNTER_ARBITER_FIXED_PRIO_EN
  // Scan downward so the lowest set index is the last (winning) assignment.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int unsigned i = NREQ; i > 0; i--) begin
      if (req_i[i-1]) begin
        pick     = IDW'(i - 1);
        pick_vld = 1'b1;
      end
    end
  end
`else
  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] w_inc;

  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      int unsigned idx;
      idx = (int'(ptr_q) + i) % NREQ;
      if (!pick_vld && req_i[idx]) begin
        pick     = IDW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  assign w_inc = (w_q == IDW'(NREQ - 1)) ? '0 : w_q + 1'b1;

  // Pointer advances past the served (or aborting) requester.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (state_q == S_DONE || abort) begin
      ptr_q <= w_inc;
    end
  end
`endif

  assign len_sel = len_i[w_q*BW +: BW];
  assign req_w   = req_i[w_q];
  assign abort   = (state_q == S_LOAD || state_q == S_RUN) && !req_w;
  assign cnt_clr = abort || (state_q == S_LOAD);
  assign cnt_en  = (state_q == S_RUN) && (count != len_q - 1'b1);

  arb_count_core #(
    .BW (BW)
  ) u_core (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .count_o (count)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      w_q     <= '0;
      len_q   <= '0;
    end else begin
      done_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (pick_vld) begin
            state_q <= S_LOAD;
            gnt_q   <= NREQ'(1) << pick;
            busy_q  <= 1'b1;
            w_q     <= pick;
          end
        end
        S_LOAD: begin
          if (!req_w) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            len_q <= len_sel;
            if (len_sel == '0) begin
              state_q <= S_DONE;
              gnt_q   <= '0;
              done_q  <= NREQ'(1) << w_q;
            end else begin
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (!req_w) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (count == len_q - 1'b1) begin
            state_q <= S_DONE;
            gnt_q   <= '0;
            done_q  <= NREQ'(1) << w_q;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt_o   = gnt_q;
  assign done_o  = done_q;
  assign busy_o  = busy_q;
  assign count_o = count;

endmodule
